// File: rtl/pulse1_reg_iface_if.sv
// CPU byte-bus bundle for the pulse channel 1 register block.
// The master drives address, data and strobes; the slave returns registered read data.
interface pulse1_reg_iface_if;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       wr;
    logic       rd;
    logic [7:0] rdata;

    modport master (output addr, output wdata, output wr, output rd, input rdata);
    modport slave  (input addr, input wdata, input wr, input rd, output rdata);
endinterface

// File: rtl/pulse1_reg_iface.sv
// Register front end for pulse channel 1: NR10-NR14/NR52 decode, trigger pulse generation
// and the frame-sequencer divider that yields clk_256/clk_128/clk_64.
module pulse1_reg_iface #(
    parameter int TRIG_CYCLES = 10,
    parameter int DIV_W       = 22,
    parameter int BIT_256     = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    pulse1_reg_iface_if.slave     bus,
    output logic                  clk_256,
    output logic                  clk_128,
    output logic                  clk_64,
    output logic [2:0]            sweep_period,
    output logic                  negate,
    output logic [2:0]            shift,
    output logic [1:0]            duty_cycle,
    output logic [5:0]            length_load,
    output logic [3:0]            starting_volume,
    output logic                  env_add,
    output logic [2:0]            period,
    output logic [10:0]           freq,
    output logic                  length_enable,
    output logic                  trigger
);

    localparam logic [7:0] TRIG_LOAD = 8'(TRIG_CYCLES);

    logic [2:0]       r_sweep_period;
    logic             r_negate;
    logic [2:0]       r_shift;
    logic [1:0]       r_duty;
    logic [5:0]       r_length_load;
    logic [7:0]       r_nr12;
    logic [10:0]      r_freq;
    logic             r_length_enable;
    logic             r_power;
    logic             r_trigger;
    logic [7:0]       r_trig_cnt;
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_rdata;

    logic             w_reg_wr;
    logic             w_pwr_wr;
    logic             w_trig_wr;
    logic [7:0]       w_rd_val;
    logic             w_unused_div;

    // Channel registers only accept writes while the APU is powered.
    assign w_reg_wr  = bus.wr && r_power;
    assign w_pwr_wr  = bus.wr && (bus.addr == 8'h26);
    assign w_trig_wr = w_reg_wr && (bus.addr == 8'h14) && bus.wdata[7];

    always_comb begin
        w_rd_val = 8'hFF;
        case (bus.addr)
            8'h10:   w_rd_val = {1'b1, r_sweep_period, r_negate, r_shift};
            8'h11:   w_rd_val = {r_duty, 6'h3F};
            8'h12:   w_rd_val = r_nr12;
            8'h13:   w_rd_val = 8'hFF;
            8'h14:   w_rd_val = {1'b1, r_length_enable, 6'h3F};
            8'h26:   w_rd_val = {r_power, 7'h70};
            default: w_rd_val = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sweep_period  <= '0;
            r_negate        <= 1'b0;
            r_shift         <= '0;
            r_duty          <= '0;
            r_length_load   <= '0;
            r_nr12          <= '0;
            r_freq          <= '0;
            r_length_enable <= 1'b0;
            r_power         <= 1'b1;
            r_trigger       <= 1'b0;
            r_trig_cnt      <= '0;
            r_div           <= '0;
            r_rdata         <= '0;
        end else begin
            // Read mux uses pre-write register values, so rd+wr in one cycle returns old data.
            if (bus.rd)
                r_rdata <= w_rd_val;

            r_div <= r_power ? r_div + DIV_W'(1) : '0;

            if (w_trig_wr) begin
                r_trig_cnt <= TRIG_LOAD;
                r_trigger  <= 1'b1;
            end else if (r_trig_cnt != 8'd0) begin
                r_trig_cnt <= r_trig_cnt - 8'd1;
                r_trigger  <= (r_trig_cnt > 8'd1);
            end

            if (w_reg_wr) begin
                case (bus.addr)
                    8'h10: begin
                        r_sweep_period <= bus.wdata[6:4];
                        r_negate       <= bus.wdata[3];
                        r_shift        <= bus.wdata[2:0];
                    end
                    8'h11: begin
                        r_duty        <= bus.wdata[7:6];
                        r_length_load <= bus.wdata[5:0];
                    end
                    8'h12: r_nr12 <= bus.wdata;
                    8'h13: r_freq[7:0] <= bus.wdata;
                    8'h14: begin
                        r_freq[10:8]    <= bus.wdata[2:0];
                        r_length_enable <= bus.wdata[6];
                    end
                    default: ;
                endcase
            end

            // Power-down wipes channel state and parks the divider; placed last so it wins.
            if (w_pwr_wr) begin
                r_power <= bus.wdata[7];
                if (!bus.wdata[7]) begin
                    r_sweep_period  <= '0;
                    r_negate        <= 1'b0;
                    r_shift         <= '0;
                    r_duty          <= '0;
                    r_length_load   <= '0;
                    r_nr12          <= '0;
                    r_freq          <= '0;
                    r_length_enable <= 1'b0;
                    r_trigger       <= 1'b0;
                    r_trig_cnt      <= '0;
                    r_div           <= '0;
                end
            end
        end
    end

    assign w_unused_div = ^r_div;

    assign bus.rdata       = r_rdata;
    assign clk_256         = r_div[BIT_256];
    assign clk_128         = r_div[BIT_256+1];
    assign clk_64          = r_div[BIT_256+2];
    assign sweep_period    = r_sweep_period;
    assign negate          = r_negate;
    assign shift           = r_shift;
    assign duty_cycle      = r_duty;
    assign length_load     = r_length_load;
    assign starting_volume = r_nr12[7:4];
    assign env_add         = r_nr12[3];
    assign period          = r_nr12[2:0];
    assign freq            = r_freq;
    assign length_enable   = r_length_enable;
    assign trigger         = r_trigger;

endmodule

// File: tb/tb_pulse1_reg_iface.sv
// Directed, table-driven bench for pulse1_reg_iface: register writes/reads, trigger pulse
// timing, power-down behaviour, divider rates and reset priority.
module tb_pulse1_reg_iface;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_256, clk_128, clk_64;
    logic [2:0]  sweep_period;
    logic        negate;
    logic [2:0]  shift;
    logic [1:0]  duty_cycle;
    logic [5:0]  length_load;
    logic [3:0]  starting_volume;
    logic        env_add;
    logic [2:0]  period;
    logic [10:0] freq;
    logic        length_enable;
    logic        trigger;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse1_reg_iface_if bus ();

    pulse1_reg_iface dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .clk_256         (clk_256),
        .clk_128         (clk_128),
        .clk_64          (clk_64),
        .sweep_period    (sweep_period),
        .negate          (negate),
        .shift           (shift),
        .duty_cycle      (duty_cycle),
        .length_load     (length_load),
        .starting_volume (starting_volume),
        .env_add         (env_add),
        .period          (period),
        .freq            (freq),
        .length_enable   (length_enable),
        .trigger         (trigger)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  rd_exp;
        logic [34:0] exp_f;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [34:0] mk(input int sp, input int ng, input int sh, input int du,
                                       input int ln, input int vo, input int en, input int pe,
                                       input int fr, input int le);
        return {3'(sp), 1'(ng), 3'(sh), 2'(du), 6'(ln), 4'(vo), 1'(en), 3'(pe), 11'(fr), 1'(le)};
    endfunction

    function automatic logic [34:0] fields();
        return {sweep_period, negate, shift, duty_cycle, length_load,
                starting_volume, env_add, period, freq, length_enable};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr    = 1'b1;
        tick();
        bus.wr    = 1'b0;
        $display("write addr=%02h data=%02h", a, d);
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] d);
        bus.addr = a;
        bus.rd   = 1'b1;
        tick();
        bus.rd   = 1'b0;
        d        = bus.rdata;
        $display("read  addr=%02h data=%02h", a, d);
    endtask

    initial begin
        logic [7:0] d;
        int n;
        int last;
        logic prev;
        logic stuck;

        vecs[0] = '{8'h10, 8'h2B, 8'hAB, mk(2,1,3,0,0,0,0,0,0,0)};
        vecs[1] = '{8'h11, 8'h52, 8'h7F, mk(2,1,3,1,18,0,0,0,0,0)};
        vecs[2] = '{8'h12, 8'hF2, 8'hF2, mk(2,1,3,1,18,15,0,2,0,0)};
        vecs[3] = '{8'h13, 8'h00, 8'hFF, mk(2,1,3,1,18,15,0,2,0,0)};
        vecs[4] = '{8'h14, 8'hC4, 8'hFF, mk(2,1,3,1,18,15,0,2,1024,1)};
        vecs[5] = '{8'h30, 8'h55, 8'hFF, mk(2,1,3,1,18,15,0,2,1024,1)};
        vecs[6] = '{8'h13, 8'hA5, 8'hFF, mk(2,1,3,1,18,15,0,2,'h4A5,1)};
        vecs[7] = '{8'h14, 8'h07, 8'hBF, mk(2,1,3,1,18,15,0,2,'h7A5,0)};
        vecs[8] = '{8'h26, 8'h80, 8'hF0, mk(2,1,3,1,18,15,0,2,'h7A5,0)};

        bus.addr = '0; bus.wdata = '0; bus.wr = 1'b0; bus.rd = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("reset_fields", fields(), 35'd0);
        chk("reset_trigger", trigger, 0);
        chk("reset_clks", {clk_64, clk_128, clk_256}, 0);
        chk("reset_rdata", bus.rdata, 8'h00);
        rd_reg(8'h26, d); chk("reset_rd26", d, 8'hF0);
        rd_reg(8'h13, d); chk("reset_rd13", d, 8'hFF);
        rd_reg(8'h30, d); chk("reset_rd30", d, 8'hFF);

        // Table: write, check fields next cycle, read back masked value
        for (int i = 0; i < 9; i++) begin
            wr_reg(vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_fields", i), fields(), vecs[i].exp_f);
            rd_reg(vecs[i].addr, d);
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].rd_exp);
        end
        repeat (15) tick();
        chk("trigger_idle", trigger, 0);

        // Same-cycle read and write returns old value; rdata holds without rd
        bus.addr = 8'h12; bus.wdata = 8'h35; bus.wr = 1'b1; bus.rd = 1'b1;
        tick();
        bus.wr = 1'b0; bus.rd = 1'b0;
        $display("rd+wr addr=12 data=35 rdata=%02h", bus.rdata);
        chk("rdwr_old", bus.rdata, 8'hF2);
        chk("rdwr_vol", starting_volume, 4'h3);
        tick();
        chk("rdata_hold", bus.rdata, 8'hF2);
        rd_reg(8'h12, d); chk("rdwr_new", d, 8'h35);

        // Single trigger pulse length
        wr_reg(8'h14, 8'hC4);
        chk("trig_rise", trigger, 1);
        n = 0;
        while (trigger && n < 50) begin n++; tick(); end
        chk("trig_len10", n, 10);

        // Retrigger 4 cycles into a pulse extends it without a gap
        wr_reg(8'h14, 8'h80);
        n = 0;
        while (trigger && n < 50) begin
            n++;
            if (n == 4) begin bus.addr = 8'h14; bus.wdata = 8'h80; bus.wr = 1'b1; end
            tick();
            bus.wr = 1'b0;
        end
        $display("retrigger pulse length=%0d", n);
        chk("trig_len14", n, 14);

        // Power off mid-pulse
        wr_reg(8'h10, 8'h7F);
        wr_reg(8'h14, 8'h80);
        tick(); tick();
        wr_reg(8'h26, 8'h00);
        chk("off_trigger", trigger, 0);
        chk("off_fields", fields(), 35'd0);
        chk("off_clks", {clk_64, clk_128, clk_256}, 0);
        wr_reg(8'h12, 8'hFF);
        chk("off_wr_ignored", fields(), 35'd0);
        rd_reg(8'h26, d); chk("off_rd26", d, 8'h70);
        rd_reg(8'h10, d); chk("off_rd10", d, 8'h80);
        repeat (20) tick();
        chk("off_trigger_stays", trigger, 0);
        wr_reg(8'h26, 8'h80);
        n = 0;
        while (!clk_256 && n < 9000) begin tick(); n++; end
        $display("power-on to clk_256 rise=%0d", n);
        chk("on_div_restart", n, 8192);
        wr_reg(8'h12, 8'h9A);
        chk("on_wr_vol", starting_volume, 4'h9);

        // Divider rates from reset
        reset = 1'b1; tick(); reset = 1'b0;
        chk("div_reset_clks", {clk_64, clk_128, clk_256}, 0);
        last = 0; prev = clk_256;
        for (int k = 1; k <= 32768; k++) begin
            tick();
            if (clk_256 != prev) begin
                chk("clk256_halfperiod", k - last, 8192);
                last = k;
                prev = clk_256;
            end
            if (k == 8191)  chk("div_8191",  {clk_64, clk_128, clk_256}, 3'b000);
            if (k == 8192)  chk("div_8192",  {clk_64, clk_128, clk_256}, 3'b001);
            if (k == 16384) chk("div_16384", {clk_64, clk_128, clk_256}, 3'b010);
            if (k == 24576) chk("div_24576", {clk_64, clk_128, clk_256}, 3'b011);
            if (k == 32768) chk("div_32768", {clk_64, clk_128, clk_256}, 3'b100);
        end
        $display("divider run done, last clk_256 toggle at %0d", last);
        chk("clk256_toggled", last, 32768);

        // Reset beats a same-cycle trigger write
        bus.addr = 8'h14; bus.wdata = 8'hC7; bus.wr = 1'b1; reset = 1'b1;
        tick();
        bus.wr = 1'b0; reset = 1'b0;
        $display("reset with write addr=14 data=C7");
        stuck = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (trigger) stuck = 1'b1;
            tick();
        end
        chk("rst_trig_never", stuck, 1'b0);
        chk("rst_wr_fields", fields(), 35'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
